// File: rtl/instruction_memory_pipe.sv
`default_nettype none
// ============================================================================
// instruction_memory_pipe: registered instruction memory with valid/ready
// handshake, alignment/range fault reporting and saturating access counters.
// Revision: 1.0
// ============================================================================
module instruction_memory_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_err,
  output logic                  resp_we,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int c_OFF  = $clog2(DATA_WIDTH / 8);
  localparam int c_IDXW = $clog2(DEPTH);
  localparam int c_HI   = c_OFF + c_IDXW;

  localparam logic [1:0] c_ERR_OK    = 2'b00;
  localparam logic [1:0] c_ERR_ALIGN = 2'b01;
  localparam logic [1:0] c_ERR_RANGE = 2'b10;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_respValid;
  logic [DATA_WIDTH-1:0] r_respData;
  logic [1:0]            r_respErr;
  logic                  r_respWe;
  logic [CNT_WIDTH-1:0]  r_rdCount;
  logic [CNT_WIDTH-1:0]  r_errCount;

  logic              w_misaligned;
  logic              w_outOfRange;
  logic              w_fault;
  logic [1:0]        w_err;
  logic [c_IDXW-1:0] w_index;
  logic              w_accept;
  logic              w_consume;
  logic              w_memWrite;

  generate
    if (c_OFF > 0) begin : g_alignChk
      assign w_misaligned = |req_addr[c_OFF-1:0];
    end else begin : g_noAlignChk
      assign w_misaligned = 1'b0;
    end

    if (c_HI < ADDR_WIDTH) begin : g_rangeChk
      assign w_outOfRange = |req_addr[ADDR_WIDTH-1:c_HI];
    end else begin : g_noRangeChk
      assign w_outOfRange = 1'b0;
    end
  endgenerate

  assign w_index = req_addr[c_HI-1:c_OFF];
  assign w_fault = w_misaligned || w_outOfRange;
  // Misalignment outranks out-of-range when both are present.
  assign w_err   = w_misaligned ? c_ERR_ALIGN :
                   w_outOfRange ? c_ERR_RANGE : c_ERR_OK;

  // Single output register, no skid: a slot frees up as soon as it drains.
  assign req_ready  = !r_respValid || resp_ready;
  assign w_accept   = req_valid && req_ready;
  assign w_consume  = r_respValid && resp_ready;
  assign w_memWrite = w_accept && req_we && !w_fault && rst_n;

  always_ff @(posedge clk) begin
    if (w_memWrite) begin
      r_mem[w_index] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respErr   <= c_ERR_OK;
      r_respWe    <= 1'b0;
      r_rdCount   <= '0;
      r_errCount  <= '0;
    end else begin
      if (w_accept) begin
        r_respValid <= 1'b1;
        r_respData  <= (req_we || w_fault) ? '0 : r_mem[w_index];
        r_respErr   <= w_err;
        r_respWe    <= req_we;
        if (w_fault) begin
          if (r_errCount != c_CNT_MAX) begin
            r_errCount <= r_errCount + c_CNT_ONE;
          end
        end else if (!req_we) begin
          if (r_rdCount != c_CNT_MAX) begin
            r_rdCount <= r_rdCount + c_CNT_ONE;
          end
        end
      end else if (w_consume) begin
        r_respValid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;
  assign resp_err   = r_respErr;
  assign resp_we    = r_respWe;
  assign rd_count   = r_rdCount;
  assign err_count  = r_errCount;

endmodule
`default_nettype wire
